// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- iterative multiply/divide unit for the 5-stage MIPS pipeline.
//
// Accepts MULTU/MULT/DIVU/DIV from the execute stage and runs 32 iterations of
// either shift-add multiply or restoring divide, one per clock. While the
// operation runs, stall_req freezes F, D and E. The result is written into the
// architectural HI/LO registers on the edge that ends the last iteration.
//
// Configuration macro:
//   MDU_SIGNED_EN  defined   -> MULT/DIV strip operand signs on entry and
//                               apply the sign fix-up when HI/LO are written.
//                  undefined -> opE[0] is ignored and MULT/DIV behave exactly
//                               like MULTU/DIVU.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-high reset
//   startE     multiply/divide instruction valid in E
//   opE        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srcaE      rs operand (multiplicand / dividend)
//   srcbE      rt operand (multiplier / divisor)
//   abort      kill the in-flight op; has priority over startE
//   stall_req  freeze F, D and E this cycle (combinational)
//   busy       iterating
//   hi, lo     architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        abort,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] LAST = 5'd31;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [63:0] acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [63:0] acc_next;
    logic [63:0] res;        // acc_next after sign fix-up, written into hi/lo
    logic [31:0] operand;    // multiplicand or divisor
    logic        is_div;
    logic        start_ok;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [32:0] rem_sh;

`ifdef MDU_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_main;          // negate product / quotient
    logic neg_rem;           // remainder follows dividend sign

    always_comb begin
        sign_a = opE[0] & srcaE[31];
        sign_b = opE[0] & srcbE[31];
        mag_a  = sign_a ? -srcaE : srcaE;
        mag_b  = sign_b ? -srcbE : srcbE;
    end
`else
    logic op_signed_unused;

    assign op_signed_unused = opE[0];
    assign mag_a = srcaE;
    assign mag_b = srcbE;
`endif

    assign start_ok = startE && !abort;

    // One iteration of the datapath.
    always_comb begin
        // NOTE: every variable written here gets a value first, so no path leaves one unassigned and infers a latch.
        sum      = {1'b0, acc[63:32]} + {1'b0, operand};
        rem_sh   = acc[63:31];
        acc_next = acc;
        if (is_div) begin
            // Restoring step: shift the remainder/quotient pair left, then
            // subtract the divisor if it fits. The shifted remainder is 33
            // bits wide, so the compare is done at 33 bits.
            acc_next = {acc[62:0], 1'b0};
            if (rem_sh >= {1'b0, operand}) begin
                acc_next[63:32] = rem_sh[31:0] - operand;
                acc_next[0]     = 1'b1;
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[31:1]};
        end else begin
            acc_next = {1'b0, acc[63:1]};
        end
    end

    // Result written on the final iteration.
    always_comb begin
        res = acc_next;
`ifdef MDU_SIGNED_EN
        if (is_div) begin
            if (neg_main) res[31:0]  = -acc_next[31:0];
            if (neg_rem)  res[63:32] = -acc_next[63:32];
        end else if (neg_main) begin
            res = -acc_next;
        end
`endif
    end

    // Next state and stall request.
    always_comb begin
        state_next = state;
        stall_req  = 1'b0;
        unique case (state)
            IDLE: begin
                stall_req = start_ok;
                if (start_ok) state_next = BUSY;
            end
            BUSY: begin
                stall_req = 1'b1;
                if (abort)              state_next = IDLE;
                else if (count == LAST) state_next = DONE;
            end
            // The instruction is still in E during DONE and leaves this cycle,
            // so startE is ignored here.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MDU_SIGNED_EN
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples values from before this edge.
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        count   <= '0;
                        is_div  <= opE[1];
                        acc     <= {32'd0, opE[1] ? mag_a : mag_b};
                        operand <= opE[1] ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
`endif
                    end
                end
                BUSY: begin
                    // An abort discards the partial result and leaves hi/lo alone.
                    if (!abort) begin
                        acc   <= acc_next;
                        count <= count + 5'd1;
                        if (count == LAST) begin
                            hi <= res[63:32];
                            lo <= res[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu.
//
// Stimulus pushes the expected {hi, lo} into a queue when an operation is
// issued (or aborted / reset); a monitor pops and compares whenever busy
// falls. Expected values come from a plain-arithmetic reference model.
// Build with +define+MDU_SIGNED_EN to exercise the signed configuration.
// -----------------------------------------------------------------------------
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'b00;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        abort = 1'b0;
    logic        stall_req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic        prev_busy = 1'b0;
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    mdu dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .abort     (abort),
        .stall_req (stall_req),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic           signed_op;
        longint         sa, sb, sp, sq, sr;
        longint unsigned up;
        logic [31:0]    q, r;
`ifdef MDU_SIGNED_EN
        signed_op = op[0];
`else
        signed_op = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[1]) begin
            if (signed_op) begin
                sp = sa * sb;
                return sp;
            end
            up = {32'd0, a} * {32'd0, b};
            return up;
        end
        if (b == 0) begin
            q = (signed_op && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (signed_op) begin
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a completed, aborted or reset operation shows as busy falling.
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=0x%0h required=none", {hi, lo});
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hi_lo", {hi, lo}, mon_exp);
            end
        end
        prev_busy = busy;
    end

    // Issue one op at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] r;
        r = ref_op(op, a, b);
        exp_q.push_back(r);
        model_hi = r[63:32];
        model_lo = r[31:0];
        opE = op; srcaE = a; srcbE = b; startE = 1'b1;
        #1;
        n = 0;
        while (stall_req && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("stall_cycles", n, 33);
        check("busy_in_done", busy, 0);
        @(posedge clk); #1;
        startE = 1'b0;
    endtask

    // Start an op and abort it at BUSY iteration k.
    task automatic abort_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        exp_q.push_back({model_hi, model_lo});
        opE = op; srcaE = a; srcbE = b; startE = 1'b1;
        repeat (k + 1) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", busy, 1);
        abort = 1'b1; startE = 1'b0;
        #1;
        check("stall_in_abort_cycle", stall_req, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("stall_after_abort", stall_req, 0);
        check("busy_after_abort", busy, 0);
        check("hi_kept", hi, model_hi);
        check("lo_kept", lo, model_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_stall", stall_req, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
`ifdef MDU_SIGNED_EN
        check("mult_hi", hi, 32'hFFFF_FFFF);
`else
        check("mult_hi", hi, 32'h0000_0004);
`endif
        check("mult_lo", lo, 32'hFFFF_FFF1);

        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
`ifdef MDU_SIGNED_EN
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
`endif

        run_op(2'b10, 32'h0000_000A, 32'h0000_0000);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h0000_000A);

        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MDU_SIGNED_EN
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
`endif
        run_op(2'b11, 32'hFFFF_FFF0, 32'h0000_0000);
        run_op(2'b11, 32'h0000_0010, 32'h0000_0000);

        // Preload, then abort mid-multiply and at the boundaries.
        run_op(2'b10, 32'd7, 32'd2);
        check("preload_hi", hi, 32'd1);
        check("preload_lo", lo, 32'd3);
        abort_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        abort_op(2'b10, 32'hFFFF_FFFF, 32'd3, 31);
        abort_op(2'b01, 32'hFFFF_FFFF, 32'd3, 0);

        // startE together with abort in IDLE does not start.
        startE = 1'b1; abort = 1'b1; opE = 2'b00;
        #1;
        check("idle_abort_stall", stall_req, 0);
        @(posedge clk); #1;
        check("idle_abort_busy", busy, 0);
        startE = 1'b0; abort = 1'b0;

        // Asynchronous reset at BUSY iteration 20.
        opE = 2'b00; srcaE = 32'hDEAD_BEEF; srcbE = 32'h0000_0101; startE = 1'b1;
        repeat (21) begin
            @(posedge clk); #1;
        end
        check("busy_before_rst", busy, 1);
        #1;
        exp_q.push_back(64'd0);
        model_hi = '0;
        model_lo = '0;
        startE = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_stall", stall_req, 0);
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(2'b00, 32'h0001_0003, 32'h0002_0005);

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the 5-stage MIPS pipeline. It is the stall-requesting counterpart of the hazard unit: it accepts MULT/MULTU/DIV/DIVU from the execute stage, runs a 32-iteration shift-add or restoring-divide datapath, and holds the pipeline through a stall request that the hazard unit ORs into stallF/stallD and uses to freeze E. Results land in architectural HI/LO registers that feed MFHI/MFLO.

## Interface
Parameters:
- none; datapath fixed at 32 bits, HI/LO 32 bits each.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- startE  in  1  a multiply/divide instruction is valid in E.
- opE  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srcaE  in  32  rs operand (forwarded value from E-stage muxes).
- srcbE  in  32  rt operand.
- abort  in  1  kill the in-flight op (exception/flush); has priority over startE.
- stall_req  out  1  to hazard unit: freeze F, D and E this cycle.
- busy  out  1  FSM in BUSY.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: state IDLE, count 0, hi 0, lo 0, busy 0, stall_req 0.
- IDLE: on startE && !abort latch operands (sign-stripped per Configuration), count <= 0, go BUSY. Otherwise stay IDLE.
- BUSY: one iteration per cycle, count 0..31. After the count==31 iteration, write hi/lo and go DONE. abort -> IDLE, hi/lo unchanged, partial result discarded.
- DONE: one cycle; startE ignored (the same instruction is still in E and leaves this cycle); always -> IDLE.
- stall_req = (state==IDLE && startE && !abort) || state==BUSY. Combinational; low in DONE.
- Multiply: 64-bit accumulator, shift-add over 32 multiplier bits; hi = product[63:32], lo = product[31:0].
- Divide: restoring, 64-bit remainder/quotient shift register; lo = quotient, hi = remainder.
- Divide by zero (unsigned): lo = 0xFFFFFFFF, hi = dividend. No trap.
- Signed fix-up, applied once at write: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend's sign. 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Signed /0: a>=0 -> lo=0xFFFFFFFF, hi=a; a<0 -> lo=1, hi=a.
- hi/lo change only on the DONE transition; MFHI/MFLO in E read them directly.

## Timing
- Cycle 0: IDLE, startE high -> stall_req high combinationally.
- Cycles 1..32: BUSY, stall_req high; busy high.
- Edge ending cycle 32: hi/lo written. Cycle 33: DONE, stall_req low, new hi/lo visible; instruction advances to M.
- Total: 33 stall cycles per op; next op accepted no earlier than cycle 34.
- abort in cycle k (0..32): state IDLE at k+1; stall_req low in cycle k when state is IDLE, in k+1 otherwise.
- rst mid-operation: immediate IDLE, hi/lo cleared, stall_req low without waiting for clk.
- startE with abort in IDLE: no start, stall_req low.

## Configuration
- MDU_SIGNED_EN defined: MULT/DIV use sign stripping and fix-up above.
- Undefined: signed-op datapath logic is omitted; opE[0] is ignored and MULT/DIV execute exactly as MULTU/DIVU (same latency).

## Test plan
- MULTU 0xFFFFFFFF x 0x00000002 -> stall_req high exactly 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- MULT 0xFFFFFFFD x 0x00000005 (MDU_SIGNED_EN) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without macro -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9 / 0x00000002 (MDU_SIGNED_EN) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x0000000A / 0 -> lo=0xFFFFFFFF, hi=0x0000000A; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via DIVU 7/2 (hi=1, lo=3), start MULTU, abort at BUSY count 10 -> IDLE next cycle, stall_req low, hi=1, lo=3 retained.
- rst pulsed asynchronously at BUSY count 20 -> hi=0, lo=0, stall_req and busy low before next edge; fresh op afterwards completes normally.
